// File: rtl/swc_rtu_pkg.sv
// ---------------------------------------------------------------------------
// swc_rtu_pkg
// Shared definitions for the RTU response queue.
//   rsp_t          : response record {mask, drop, prio}, sized for the widest
//                    supported configuration (16 ports, 8-bit priority).
//   swc_rtu_log2() : ceiling log2, used to size pointers and occupancy counts.
// ---------------------------------------------------------------------------
package swc_rtu_pkg;

  localparam int c_max_ports      = 16;
  localparam int c_max_prio_width = 8;

  typedef struct packed {
    logic [c_max_ports-1:0]      mask;
    logic                        drop;
    logic [c_max_prio_width-1:0] prio;
  } rsp_t;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int swc_rtu_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/swc_rtu_rsp_fifo.sv
// ---------------------------------------------------------------------------
// swc_rtu_rsp_fifo
// Single-port first-word-fall-through response FIFO with occupancy count and
// sticky overflow flag.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   wr_i, mask_i,
//   drop_i, prio_i      : enqueue strobe and entry fields
//   full_o              : occupancy == g_depth
//   valid_o, ack_i      : head entry present / consume head
//   mask_o, drop_o,
//   prio_o              : head entry fields
//   usedw_o             : occupancy (one bit wider than the pointers)
//   ovf_o, ovf_clr_i    : sticky overflow flag and its clear strobe
// ---------------------------------------------------------------------------
module swc_rtu_rsp_fifo
  import swc_rtu_pkg::*;
#(
  parameter int  g_mask_width     = 7,
  parameter int  g_prio_width     = 3,
  parameter int  g_depth          = 4,
  parameter int  g_zero_mask_drop = 1,
  localparam int c_aw             = swc_rtu_log2(g_depth),
  localparam int c_uw             = c_aw + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_i,
  input  logic [g_mask_width-1:0] mask_i,
  input  logic                    drop_i,
  input  logic [g_prio_width-1:0] prio_i,
  output logic                    full_o,
  output logic                    valid_o,
  input  logic                    ack_i,
  output logic [g_mask_width-1:0] mask_o,
  output logic                    drop_o,
  output logic [g_prio_width-1:0] prio_o,
  output logic [c_uw-1:0]         usedw_o,
  output logic                    ovf_o,
  input  logic                    ovf_clr_i
);

  localparam int              c_ew   = g_mask_width + 1 + g_prio_width;
  localparam logic [c_uw-1:0] c_full = c_uw'(g_depth);

  logic [c_ew-1:0] mem_q [g_depth];
  logic [c_aw-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_aw-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_uw-1:0] usedw_q, usedw_d;
  logic            ovf_q, ovf_d;

  logic            is_empty, is_full;
  logic            push, pop, ovf_set, drop_eff;
  logic [c_ew-1:0] wr_entry;

  always_comb begin
    is_empty = (usedw_q == '0);
    is_full  = (usedw_q == c_full);
    // Ack on an empty FIFO is ignored.
    pop      = ack_i && !is_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push     = wr_i && (!is_full || pop);
    ovf_set  = wr_i && is_full && !pop;

    drop_eff = drop_i || ((g_zero_mask_drop != 0) && (mask_i == '0));
    wr_entry = {mask_i, drop_eff, prio_i};

    wr_ptr_d = push ? (wr_ptr_q + c_aw'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + c_aw'(1)) : rd_ptr_q;

    usedw_d = usedw_q;
    if (push && !pop) begin
      usedw_d = usedw_q + c_uw'(1);
    end else if (pop && !push) begin
      usedw_d = usedw_q - c_uw'(1);
    end

    // A new overflow wins over a simultaneous clear.
    ovf_d = (ovf_q && !ovf_clr_i) || ovf_set;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; the occupancy count alone defines which slots hold data.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  // Head fields come straight from the storage registers, giving the
  // one-cycle write-to-valid fall-through.
  assign {mask_o, drop_o, prio_o} = mem_q[rd_ptr_q];
  assign valid_o = (usedw_q != '0);
  assign full_o  = (usedw_q == c_full);
  assign usedw_o = usedw_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/swc_rtu_rsp_queue.sv
// ---------------------------------------------------------------------------
// swc_rtu_rsp_queue
// Bank of independent per-port RTU response FIFOs feeding the switch core.
// All per-port buses are flattened, port p occupying slice p of each bus.
//   clk_i, rst_i                  : clock, asynchronous active-high reset
//   req_wr_i/req_mask_i/
//   req_drop_i/req_prio_i         : per-port enqueue strobe and entry
//   req_full_o                    : per-port FIFO full
//   rtu_rsp_valid_o/rtu_rsp_ack_i : per-port head valid / consume
//   rtu_dst_port_mask_o/
//   rtu_drop_o/rtu_prio_o         : per-port head entry fields
//   usedw_o                       : per-port occupancy
//   ovf_o/ovf_clr_i               : per-port sticky overflow and clear
// ---------------------------------------------------------------------------
module swc_rtu_rsp_queue
  import swc_rtu_pkg::*;
#(
  parameter int  g_num_ports      = 7,
  parameter int  g_prio_width     = 3,
  parameter int  g_depth          = 4,
  parameter int  g_zero_mask_drop = 1,
  localparam int c_uw             = swc_rtu_log2(g_depth) + 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [g_num_ports-1:0]              req_wr_i,
  input  logic [g_num_ports*g_num_ports-1:0]  req_mask_i,
  input  logic [g_num_ports-1:0]              req_drop_i,
  input  logic [g_num_ports*g_prio_width-1:0] req_prio_i,
  output logic [g_num_ports-1:0]              req_full_o,
  output logic [g_num_ports-1:0]              rtu_rsp_valid_o,
  input  logic [g_num_ports-1:0]              rtu_rsp_ack_i,
  output logic [g_num_ports*g_num_ports-1:0]  rtu_dst_port_mask_o,
  output logic [g_num_ports-1:0]              rtu_drop_o,
  output logic [g_num_ports*g_prio_width-1:0] rtu_prio_o,
  output logic [g_num_ports*c_uw-1:0]         usedw_o,
  output logic [g_num_ports-1:0]              ovf_o,
  input  logic [g_num_ports-1:0]              ovf_clr_i
);

  localparam int N  = g_num_ports;
  localparam int PW = g_prio_width;

  for (genvar gi = 0; gi < N; gi++) begin : g_port
    swc_rtu_rsp_fifo #(
      .g_mask_width     (N),
      .g_prio_width     (PW),
      .g_depth          (g_depth),
      .g_zero_mask_drop (g_zero_mask_drop)
    ) u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_i      (req_wr_i[gi]),
      .mask_i    (req_mask_i[gi*N +: N]),
      .drop_i    (req_drop_i[gi]),
      .prio_i    (req_prio_i[gi*PW +: PW]),
      .full_o    (req_full_o[gi]),
      .valid_o   (rtu_rsp_valid_o[gi]),
      .ack_i     (rtu_rsp_ack_i[gi]),
      .mask_o    (rtu_dst_port_mask_o[gi*N +: N]),
      .drop_o    (rtu_drop_o[gi]),
      .prio_o    (rtu_prio_o[gi*PW +: PW]),
      .usedw_o   (usedw_o[gi*c_uw +: c_uw]),
      .ovf_o     (ovf_o[gi]),
      .ovf_clr_i (ovf_clr_i[gi])
    );
  end

endmodule

// File: tb/tb_swc_rtu_rsp_queue.sv
// Testbench for swc_rtu_rsp_queue: a default instance (zero-mask drop on) and
// a second instance with zero-mask drop off sharing the same stimulus.
module tb_swc_rtu_rsp_queue;
  import swc_rtu_pkg::*;

  localparam int N  = 7;
  localparam int PW = 3;
  localparam int D  = 4;
  localparam int UW = 3;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_wr;
  logic [N*N-1:0]  req_mask;
  logic [N-1:0]    req_drop;
  logic [N*PW-1:0] req_prio;
  logic [N-1:0]    rsp_ack;
  logic [N-1:0]    ovf_clr;

  logic [N-1:0]    req_full,  req_full_b;
  logic [N-1:0]    rsp_valid, rsp_valid_b;
  logic [N*N-1:0]  rsp_mask,  rsp_mask_b;
  logic [N-1:0]    rsp_drop,  rsp_drop_b;
  logic [N*PW-1:0] rsp_prio,  rsp_prio_b;
  logic [N*UW-1:0] usedw,     usedw_b;
  logic [N-1:0]    ovf,       ovf_b;

  int checks = 0;
  int errors = 0;

  rsp_t sb [N][$];
  bit   exp_ovf [N];

  swc_rtu_rsp_queue #(
    .g_num_ports(N), .g_prio_width(PW), .g_depth(D), .g_zero_mask_drop(1)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_wr_i(req_wr), .req_mask_i(req_mask), .req_drop_i(req_drop), .req_prio_i(req_prio),
    .req_full_o(req_full), .rtu_rsp_valid_o(rsp_valid), .rtu_rsp_ack_i(rsp_ack),
    .rtu_dst_port_mask_o(rsp_mask), .rtu_drop_o(rsp_drop), .rtu_prio_o(rsp_prio),
    .usedw_o(usedw), .ovf_o(ovf), .ovf_clr_i(ovf_clr)
  );

  swc_rtu_rsp_queue #(
    .g_num_ports(N), .g_prio_width(PW), .g_depth(D), .g_zero_mask_drop(0)
  ) dut_b (
    .clk_i(clk), .rst_i(rst),
    .req_wr_i(req_wr), .req_mask_i(req_mask), .req_drop_i(req_drop), .req_prio_i(req_prio),
    .req_full_o(req_full_b), .rtu_rsp_valid_o(rsp_valid_b), .rtu_rsp_ack_i(rsp_ack),
    .rtu_dst_port_mask_o(rsp_mask_b), .rtu_drop_o(rsp_drop_b), .rtu_prio_o(rsp_prio_b),
    .usedw_o(usedw_b), .ovf_o(ovf_b), .ovf_clr_i(ovf_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- stimulus / model helpers (no comparisons) --------------
  task automatic clear_inputs();
    req_wr = '0; req_mask = '0; req_drop = '0; req_prio = '0;
    rsp_ack = '0; ovf_clr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_push(input int p, input logic [N-1:0] m, input logic d, input logic [PW-1:0] pr);
    req_wr[p]            = 1'b1;
    req_mask[p*N +: N]   = m;
    req_drop[p]          = d;
    req_prio[p*PW +: PW] = pr;
  endtask

  function automatic rsp_t mk_rsp(input logic [N-1:0] m, input logic d, input logic [PW-1:0] pr, input bit zm);
    rsp_t r;
    r.mask = 16'(m);
    r.drop = d | (zm && (m == '0));
    r.prio = 8'(pr);
    return r;
  endfunction

  function automatic logic [15:0] out_mask(input int p);
    return 16'(rsp_mask[p*N +: N]);
  endfunction

  function automatic logic [7:0] out_prio(input int p);
    return 8'(rsp_prio[p*PW +: PW]);
  endfunction

  function automatic logic [UW-1:0] out_usedw(input int p);
    return usedw[p*UW +: UW];
  endfunction

  // ---------------- tests --------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
    checks++; if (req_full !== '0) begin errors++; $display("FAIL reset_full got %b want 0", req_full); end
    checks++; if (usedw !== '0) begin errors++; $display("FAIL reset_usedw got %h want 0", usedw); end
    checks++; if (ovf !== '0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    checks++; if (rsp_valid_b !== '0) begin errors++; $display("FAIL reset_valid_b got %b want 0", rsp_valid_b); end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single_push();
    rsp_t e;
    set_push(2, 7'h10, 1'b0, 3'd5);
    sb[2].push_back(mk_rsp(7'h10, 1'b0, 3'd5, 1'b1));
    step(); clear_inputs();
    checks++; if (rsp_valid[2] !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", rsp_valid[2]); end
    checks++; if (out_usedw(2) !== 3'd1) begin errors++; $display("FAIL single_usedw got %0d want 1", out_usedw(2)); end
    e = sb[2].pop_front();
    checks++; if (out_mask(2) !== e.mask) begin errors++; $display("FAIL single_mask got %h want %h", out_mask(2), e.mask); end
    checks++; if (out_prio(2) !== e.prio) begin errors++; $display("FAIL single_prio got %0d want %0d", out_prio(2), e.prio); end
    checks++; if (rsp_drop[2] !== e.drop) begin errors++; $display("FAIL single_drop got %b want %b", rsp_drop[2], e.drop); end
    rsp_ack[2] = 1'b1;
    step(); clear_inputs();
    checks++; if (rsp_valid[2] !== 1'b0) begin errors++; $display("FAIL single_pop_valid got %b want 0", rsp_valid[2]); end
    checks++; if (out_usedw(2) !== 3'd0) begin errors++; $display("FAIL single_pop_usedw got %0d want 0", out_usedw(2)); end
    $display("test_single_push done");
  endtask

  task automatic test_overflow();
    rsp_t e;
    for (int i = 0; i < 5; i++) begin
      set_push(0, 7'(i + 1), 1'b0, 3'(i));
      if (i < D) sb[0].push_back(mk_rsp(7'(i + 1), 1'b0, 3'(i), 1'b1));
      step(); clear_inputs();
      checks++; if (req_full[0] !== (i >= D - 1)) begin errors++; $display("FAIL ovf_full[%0d] got %b want %b", i, req_full[0], (i >= D - 1)); end
      checks++; if (out_usedw(0) !== UW'((i < D) ? i + 1 : D)) begin errors++; $display("FAIL ovf_usedw[%0d] got %0d", i, out_usedw(0)); end
    end
    checks++; if (ovf[0] !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", ovf[0]); end
    // New overflow and clear in the same cycle: flag must stay set.
    set_push(0, 7'h7f, 1'b0, 3'd7);
    ovf_clr[0] = 1'b1;
    step(); clear_inputs();
    checks++; if (ovf[0] !== 1'b1) begin errors++; $display("FAIL ovf_clr_collide got %b want 1", ovf[0]); end
    checks++; if (out_usedw(0) !== 3'd4) begin errors++; $display("FAIL ovf_usedw_hold got %0d want 4", out_usedw(0)); end
    ovf_clr[0] = 1'b1;
    step(); clear_inputs();
    checks++; if (ovf[0] !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", ovf[0]); end
    for (int i = 0; i < D; i++) begin
      e = sb[0].pop_front();
      checks++; if (rsp_valid[0] !== 1'b1 || out_mask(0) !== e.mask || out_prio(0) !== e.prio) begin
        errors++; $display("FAIL ovf_drain[%0d] got v%b m%h p%0d want m%h p%0d", i, rsp_valid[0], out_mask(0), out_prio(0), e.mask, e.prio);
      end
      rsp_ack[0] = 1'b1;
      step(); clear_inputs();
    end
    checks++; if (out_usedw(0) !== 3'd0 || req_full[0] !== 1'b0) begin errors++; $display("FAIL ovf_drained got u%0d f%b want 0 0", out_usedw(0), req_full[0]); end
    $display("test_overflow done");
  endtask

  task automatic test_full_push_ack();
    rsp_t e;
    for (int i = 0; i < D; i++) begin
      set_push(1, 7'(8 + i), 1'b0, 3'(i));
      sb[1].push_back(mk_rsp(7'(8 + i), 1'b0, 3'(i), 1'b1));
      step(); clear_inputs();
    end
    checks++; if (req_full[1] !== 1'b1) begin errors++; $display("FAIL fpa_full got %b want 1", req_full[1]); end
    e = sb[1].pop_front();
    checks++; if (out_mask(1) !== e.mask) begin errors++; $display("FAIL fpa_head got %h want %h", out_mask(1), e.mask); end
    set_push(1, 7'h55, 1'b1, 3'd7);
    sb[1].push_back(mk_rsp(7'h55, 1'b1, 3'd7, 1'b1));
    rsp_ack[1] = 1'b1;
    step(); clear_inputs();
    checks++; if (out_usedw(1) !== 3'd4) begin errors++; $display("FAIL fpa_usedw got %0d want 4", out_usedw(1)); end
    checks++; if (ovf[1] !== 1'b0) begin errors++; $display("FAIL fpa_ovf got %b want 0", ovf[1]); end
    for (int i = 0; i < D; i++) begin
      e = sb[1].pop_front();
      checks++; if (out_mask(1) !== e.mask || out_prio(1) !== e.prio || rsp_drop[1] !== e.drop) begin
        errors++; $display("FAIL fpa_order[%0d] got m%h p%0d d%b want m%h p%0d d%b", i, out_mask(1), out_prio(1), rsp_drop[1], e.mask, e.prio, e.drop);
      end
      rsp_ack[1] = 1'b1;
      step(); clear_inputs();
    end
    checks++; if (rsp_valid[1] !== 1'b0) begin errors++; $display("FAIL fpa_empty got %b want 0", rsp_valid[1]); end
    $display("test_full_push_ack done");
  endtask

  task automatic test_empty_push_ack();
    // Ack alone on an empty FIFO must not underflow.
    rsp_ack[5] = 1'b1;
    step(); clear_inputs();
    checks++; if (out_usedw(5) !== 3'd0) begin errors++; $display("FAIL empty_ack_usedw got %0d want 0", out_usedw(5)); end
    // Write plus ack on empty: write lands, ack ignored.
    set_push(4, 7'h21, 1'b0, 3'd3);
    rsp_ack[4] = 1'b1;
    step(); clear_inputs();
    checks++; if (out_usedw(4) !== 3'd1) begin errors++; $display("FAIL empty_wa_usedw got %0d want 1", out_usedw(4)); end
    checks++; if (out_mask(4) !== 16'h0021) begin errors++; $display("FAIL empty_wa_mask got %h want 0021", out_mask(4)); end
    rsp_ack[4] = 1'b1;
    step(); clear_inputs();
    $display("test_empty_push_ack done");
  endtask

  task automatic test_zero_mask();
    set_push(3, 7'h00, 1'b0, 3'd2);
    step(); clear_inputs();
    checks++; if (rsp_valid[3] !== 1'b1 || rsp_drop[3] !== 1'b1) begin errors++; $display("FAIL zmask_drop_on got v%b d%b want 1 1", rsp_valid[3], rsp_drop[3]); end
    checks++; if (rsp_valid_b[3] !== 1'b1 || rsp_drop_b[3] !== 1'b0) begin errors++; $display("FAIL zmask_drop_off got v%b d%b want 1 0", rsp_valid_b[3], rsp_drop_b[3]); end
    rsp_ack[3] = 1'b1;
    step(); clear_inputs();
    $display("test_zero_mask done");
  endtask

  task automatic test_random();
    rsp_t e;
    logic [N-1:0] wr, ack;
    for (int p = 0; p < N; p++) exp_ovf[p] = 1'b0;
    for (int it = 0; it < 100; it++) begin
      wr  = N'($urandom);
      ack = N'($urandom);
      for (int p = 0; p < N; p++) begin
        int  sz;
        bit  popped;
        logic [N-1:0]  m;
        logic          d;
        logic [PW-1:0] pr;
        sz = sb[p].size();
        checks++; if (rsp_valid[p] !== (sz != 0) || out_usedw(p) !== UW'(sz)) begin
          errors++; $display("FAIL rnd_occ it%0d p%0d got v%b u%0d want %0d", it, p, rsp_valid[p], out_usedw(p), sz);
        end
        checks++; if (ovf[p] !== exp_ovf[p]) begin errors++; $display("FAIL rnd_ovf it%0d p%0d got %b want %b", it, p, ovf[p], exp_ovf[p]); end
        popped = ack[p] && (sz > 0);
        if (popped) begin
          e = sb[p].pop_front();
          checks++; if (out_mask(p) !== e.mask || out_prio(p) !== e.prio || rsp_drop[p] !== e.drop) begin
            errors++; $display("FAIL rnd_head it%0d p%0d got m%h p%0d d%b want m%h p%0d d%b", it, p, out_mask(p), out_prio(p), rsp_drop[p], e.mask, e.prio, e.drop);
          end
        end
        if (wr[p]) begin
          m  = N'($urandom);
          d  = 1'($urandom);
          pr = PW'($urandom);
          set_push(p, m, d, pr);
          if (sz < D || popped) sb[p].push_back(mk_rsp(m, d, pr, 1'b1));
          else exp_ovf[p] = 1'b1;
        end
      end
      rsp_ack = ack;
      $display("rnd it %0d wr %b ack %b", it, wr, ack);
      step(); clear_inputs();
    end
    // Drain everything with a bounded number of cycles.
    for (int c = 0; c < 2 * D; c++) begin
      for (int p = 0; p < N; p++) begin
        if (sb[p].size() > 0) begin
          e = sb[p].pop_front();
          checks++; if (rsp_valid[p] !== 1'b1 || out_mask(p) !== e.mask || out_prio(p) !== e.prio || rsp_drop[p] !== e.drop) begin
            errors++; $display("FAIL rnd_drain p%0d got v%b m%h p%0d d%b want m%h p%0d d%b", p, rsp_valid[p], out_mask(p), out_prio(p), rsp_drop[p], e.mask, e.prio, e.drop);
          end
          rsp_ack[p] = 1'b1;
        end
      end
      step(); clear_inputs();
    end
    checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL rnd_drained got %b want 0", rsp_valid); end
    ovf_clr = '1;
    step(); clear_inputs();
    checks++; if (ovf !== '0) begin errors++; $display("FAIL rnd_ovf_clr got %b want 0", ovf); end
    $display("test_random done");
  endtask

  task automatic test_reset_mid();
    rsp_t e;
    for (int i = 0; i < D + 1; i++) begin
      for (int p = 0; p < N; p++) set_push(p, 7'(p + 1), 1'b0, 3'(i));
      step(); clear_inputs();
    end
    checks++; if (req_full !== '1 || ovf !== '1) begin errors++; $display("FAIL rmid_pre got f%b o%b want all 1", req_full, ovf); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL rmid_valid got %b want 0", rsp_valid); end
    checks++; if (req_full !== '0) begin errors++; $display("FAIL rmid_full got %b want 0", req_full); end
    checks++; if (usedw !== '0) begin errors++; $display("FAIL rmid_usedw got %h want 0", usedw); end
    checks++; if (ovf !== '0) begin errors++; $display("FAIL rmid_ovf got %b want 0", ovf); end
    @(negedge clk);
    rst = 1'b0;
    for (int p = 0; p < N; p++) sb[p].delete();
    set_push(1, 7'h3c, 1'b0, 3'd6);
    sb[1].push_back(mk_rsp(7'h3c, 1'b0, 3'd6, 1'b1));
    step(); clear_inputs();
    e = sb[1].pop_front();
    checks++; if (rsp_valid[1] !== 1'b1 || out_usedw(1) !== 3'd1) begin errors++; $display("FAIL rmid_resume got v%b u%0d want 1 1", rsp_valid[1], out_usedw(1)); end
    checks++; if (out_mask(1) !== e.mask || out_prio(1) !== e.prio) begin errors++; $display("FAIL rmid_data got m%h p%0d want m%h p%0d", out_mask(1), out_prio(1), e.mask, e.prio); end
    rsp_ack[1] = 1'b1;
    step(); clear_inputs();
    checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL rmid_final got %b want 0", rsp_valid); end
    $display("test_reset_mid done");
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_push();
    test_overflow();
    test_full_push_ack();
    test_empty_push_ack();
    test_zero_mask();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/swc_rtu_rsp_queue.md
SWC_RTU_RSP_QUEUE -- requirements
Module: swc_rtu_rsp_queue

Interface
REQ-001 Parameter g_num_ports, default 7: number of switch ports/channels, range 2..16.
REQ-002 Parameter g_prio_width, default 3: priority field width.
REQ-003 Parameter g_depth, default 4: per-port response FIFO depth, power of two, range 2..16.
REQ-004 Parameter g_zero_mask_drop, default 1: a mask of all-zero forces drop=1 on enqueue.
REQ-005 clk_i  in  1  single system clock, all logic on rising edge.
REQ-006 rst_i  in  1  asynchronous, active-high reset.
REQ-007 req_wr_i  in  N  per-port enqueue strobe; N = g_num_ports.
REQ-008 req_mask_i  in  N*N  flattened destination masks, port p at bits [(p+1)*N-1 : p*N].
REQ-009 req_drop_i  in  N  per-port drop flag.
REQ-010 req_prio_i  in  N*g_prio_width  flattened priorities, same packing as masks.
REQ-011 req_full_o  out  N  per-port FIFO full.
REQ-012 rtu_rsp_valid_o  out  N  head entry valid, towards swcore.
REQ-013 rtu_rsp_ack_i  in  N  swcore consumes head entry.
REQ-014 rtu_dst_port_mask_o / rtu_drop_o / rtu_prio_o  out  N*N / N / N*g_prio_width  head entry fields.
REQ-015 usedw_o  out  N*(log2(g_depth)+1)  per-port occupancy.
REQ-016 ovf_o  out  N  sticky per-port overflow flag.
REQ-017 ovf_clr_i  in  N  per-port overflow clear strobe.

Function
REQ-018 Each port SHALL own an independent FIFO of g_depth entries {mask, drop, prio}; ports never interact.
REQ-019 FIFO SHALL be first-word-fall-through: entry written at edge k appears on outputs with valid=1 after edge k (1-cycle latency).
REQ-020 rtu_rsp_valid_o[p] SHALL equal (usedw[p] != 0); head fields are don't-care but held stable while valid=1 and no ack.
REQ-021 rtu_rsp_ack_i[p] with valid=1 SHALL pop one entry at that edge; ack with valid=0 SHALL be ignored.
REQ-022 Write when not full SHALL push; write when full and no simultaneous ack SHALL discard the entry and set ovf_o[p].
REQ-023 Write and ack in the same cycle on a full FIFO SHALL both take effect; usedw unchanged, no overflow.
REQ-024 Write and ack in the same cycle on an empty FIFO: ack ignored, write pushed, usedw becomes 1.
REQ-025 With g_zero_mask_drop=1, an enqueued entry with mask=0 SHALL be stored with drop=1; with 0, stored unchanged.
REQ-026 Read/write pointers SHALL be log2(g_depth) bits and wrap modulo g_depth; usedw is one bit wider to distinguish full from empty.
REQ-027 req_full_o[p] SHALL be (usedw[p] == g_depth), registered-state derived, no combinational path from req_wr_i.
REQ-028 ovf_o[p] SHALL remain set until ovf_clr_i[p]; clear and new overflow in the same cycle leaves ovf_o[p]=1.
REQ-029 No combinational path from any input to any output except none; all outputs derive from registers.

Reset
REQ-030 rst_i assertion SHALL immediately, irrespective of clock, empty all FIFOs: valid=0, full=0, usedw=0, ovf=0, pointers=0.
REQ-031 Entries in flight at reset mid-operation SHALL be lost; storage array contents need not be reset.
REQ-032 First enqueue accepted on the first rising edge after rst_i deasserts.

Structure
REQ-033 Shared package swc_rtu_pkg SHALL hold the response record type {mask, drop, prio} and the log2 helper function.
REQ-034 One sub-module swc_rtu_rsp_fifo (single-port FIFO, FWFT, usedw, ovf) SHALL be instantiated g_num_ports times by generate.

Verification
REQ-035 Single push port 2, mask=0x10, prio=5, drop=0 -> next cycle valid[2]=1, mask out 0x10, prio 5; ack -> valid[2]=0, usedw 0.
REQ-036 Push 5 entries into port 0 (depth 4), no ack -> full[0]=1 after 4th, 5th discarded, ovf[0]=1, usedw=4; ovf_clr -> ovf=0.
REQ-037 Port 1 full, push+ack same cycle -> usedw stays 4, ovf=0, new entry appears last after 4 pops in order.
REQ-038 Push mask=0, drop=0 with g_zero_mask_drop=1 -> drop out 1; with 0 -> drop out 0.
REQ-039 All 7 ports push 3 entries concurrently with random acks, 100 iterations -> per-port output order equals input order, no cross-port corruption.
REQ-040 Assert rst_i mid-traffic between edges -> all valid/full/usedw/ovf zero before next edge; traffic resumes correctly after release.
